mf_threshold_trigger: RTL and testbench

Threshold trigger stage directly downstream of the systolic matched-filter stage. Each clock it consumes the two signed filter outputs (sample 0 earlier in time, sample 1 later) and forms their magnitudes. It fires a trigger pulse on the first magnitude strictly above a programmable threshold. It then tracks the peak magnitude over a fixed window and enforces a programmable holdoff before re-arming.

---
 rtl/mf_trig_pkg.sv | 14 +
 rtl/mf_abs_cmp.sv | 32 +++
 rtl/mf_threshold_trigger.sv | 154 +++++++++++++++
 tb/tb_mf_threshold_trigger.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mf_trig_pkg.sv
// Shared types and constants for the matched-filter threshold trigger.
package mf_trig_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PEAK,
        HOLDOFF
    } state_t;

    localparam int DEFAULT_PEAK_LEN = 8;
    localparam int TRIG_COUNT_BITS  = 16;

endpackage

// File: rtl/mf_abs_cmp.sv
// Registered magnitude of one signed filter sample followed by a registered
// strict-greater compare against the threshold; mag and hit share 2-clock latency.
module mf_abs_cmp #(
    parameter int INBITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INBITS-1:0] sample,
    input  logic [INBITS-1:0] thresh,
    output logic [INBITS-1:0] mag,
    output logic              hit
);

    logic [INBITS-1:0] abs_val;
    logic [INBITS-1:0] mag_q;

    // The most negative input wraps to 2^(INBITS-1), which is exact as unsigned.
    assign abs_val = sample[INBITS-1] ? (~sample + 1'b1) : sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q <= '0;
            mag   <= '0;
            hit   <= 1'b0;
        end else begin
            mag_q <= abs_val;
            mag   <= mag_q;
            hit   <= (mag_q > thresh);
        end
    end

endmodule

// File: rtl/mf_threshold_trigger.sv
// Threshold trigger after the matched filter: fires on the first magnitude above
// threshold, reports the window peak, then holds off before re-arming.
module mf_threshold_trigger
    import mf_trig_pkg::*;
#(
    parameter int INBITS       = 16,
    parameter int PEAK_LEN     = DEFAULT_PEAK_LEN,
    parameter int HOLDOFF_BITS = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [INBITS-1:0]               in0_i,
    input  logic [INBITS-1:0]               in1_i,
    input  logic [INBITS-1:0]               thresh_i,
    input  logic [HOLDOFF_BITS-1:0]         holdoff_i,
    input  logic                            arm_i,
    output logic                            trig_o,
    output logic                            trig_idx_o,
    output logic                            peak_valid_o,
    output logic [INBITS-1:0]               peak_o,
    output logic [$clog2(2*PEAK_LEN)-1:0]   peak_idx_o,
    output logic [TRIG_COUNT_BITS-1:0]      trig_count_o
);

    localparam int IDXW = $clog2(2*PEAK_LEN);
    localparam logic [IDXW-1:0] LAST_OFFSET = IDXW'(PEAK_LEN - 1);

    logic [INBITS-1:0] thresh_r;
    logic [1:0]        vld;
    logic [INBITS-1:0] mag0, mag1;
    logic              hit0, hit1;

    state_t                   state, state_next;
    logic [IDXW-1:0]          win_cnt, win_next;
    logic [INBITS-1:0]        track_peak, track_peak_next;
    logic [IDXW-1:0]          track_idx, track_idx_next;
    logic [HOLDOFF_BITS-1:0]  hold_cnt, hold_next;
    logic                     trig_next, trig_idx_next, peak_valid_next;
    logic [INBITS-1:0]        peak_next;
    logic [IDXW-1:0]          peak_idx_next;
    logic [TRIG_COUNT_BITS-1:0] count_next;

    logic              pair_hit, pair_sel;
    logic [INBITS-1:0] pair_mag;
    logic [IDXW-1:0]   next_offset;

    // vld tracks whether each in-flight pair was presented while armed, so pairs
    // that entered the pipeline while disarmed can never trigger after re-arm.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            thresh_r <= '0;
            vld      <= '0;
        end else begin
            thresh_r <= thresh_i;
            vld      <= {vld[0], arm_i};
        end
    end

    mf_abs_cmp #(.INBITS(INBITS)) u_abs0 (
        .clk(clk_i), .rst(rst_i), .sample(in0_i), .thresh(thresh_r), .mag(mag0), .hit(hit0)
    );

    mf_abs_cmp #(.INBITS(INBITS)) u_abs1 (
        .clk(clk_i), .rst(rst_i), .sample(in1_i), .thresh(thresh_r), .mag(mag1), .hit(hit1)
    );

    // Best of the pair with ties going to the earlier sample 0.
    assign pair_hit    = vld[1] & (hit0 | hit1);
    assign pair_sel    = (mag1 > mag0);
    assign pair_mag    = pair_sel ? mag1 : mag0;
    assign next_offset = win_cnt + 1'b1;

    always_comb begin
        state_next      = state;
        win_next        = win_cnt;
        track_peak_next = track_peak;
        track_idx_next  = track_idx;
        hold_next       = hold_cnt;
        trig_next       = 1'b0;
        trig_idx_next   = trig_idx_o;
        peak_valid_next = 1'b0;
        peak_next       = peak_o;
        peak_idx_next   = peak_idx_o;
        count_next      = trig_count_o;

        case (state)
            IDLE: begin
                if (arm_i) state_next = ARMED;
            end
            ARMED: begin
                if (pair_hit) begin
                    state_next      = PEAK;
                    trig_next       = 1'b1;
                    trig_idx_next   = ~hit0;
                    count_next      = (trig_count_o == '1) ? trig_count_o : trig_count_o + 1'b1;
                    win_next        = '0;
                    track_peak_next = pair_mag;
                    track_idx_next  = IDXW'(pair_sel);
                end
            end
            PEAK: begin
                if (win_cnt == LAST_OFFSET) begin
                    state_next      = HOLDOFF;
                    peak_valid_next = 1'b1;
                    peak_next       = track_peak;
                    peak_idx_next   = track_idx;
                    hold_next       = holdoff_i;
                end else begin
                    win_next = next_offset;
                    if (pair_mag > track_peak) begin
                        track_peak_next = pair_mag;
                        track_idx_next  = IDXW'({next_offset, pair_sel});
                    end
                end
            end
            HOLDOFF: begin
                if (hold_cnt == '0) state_next = ARMED;
                else                hold_next  = hold_cnt - 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (!arm_i) state_next = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            win_cnt      <= '0;
            track_peak   <= '0;
            track_idx    <= '0;
            hold_cnt     <= '0;
            trig_o       <= 1'b0;
            trig_idx_o   <= 1'b0;
            peak_valid_o <= 1'b0;
            peak_o       <= '0;
            peak_idx_o   <= '0;
            trig_count_o <= '0;
        end else begin
            state        <= state_next;
            win_cnt      <= win_next;
            track_peak   <= track_peak_next;
            track_idx    <= track_idx_next;
            hold_cnt     <= hold_next;
            trig_o       <= trig_next;
            trig_idx_o   <= trig_idx_next;
            peak_valid_o <= peak_valid_next;
            peak_o       <= peak_next;
            peak_idx_o   <= peak_idx_next;
            trig_count_o <= count_next;
        end
    end

endmodule

// File: tb/tb_mf_threshold_trigger.sv
// Self-checking bench for mf_threshold_trigger: directed scenarios with expected
// timing from the trigger rules, plus randomized runs against an event-level model.
module tb_mf_threshold_trigger;

    localparam int L    = 8;
    localparam int MAXC = 256;

    logic        clk = 1'b0;
    logic        rst, arm;
    logic [15:0] in0, in1, thresh, holdoff;
    logic        trig_o, trig_idx_o, peak_valid_o;
    logic [15:0] peak_o;
    logic [3:0]  peak_idx_o;
    logic [15:0] trig_count_o;

    always #5 clk = ~clk;

    mf_threshold_trigger dut (
        .clk_i(clk), .rst_i(rst), .in0_i(in0), .in1_i(in1), .thresh_i(thresh),
        .holdoff_i(holdoff), .arm_i(arm), .trig_o(trig_o), .trig_idx_o(trig_idx_o),
        .peak_valid_o(peak_valid_o), .peak_o(peak_o), .peak_idx_o(peak_idx_o),
        .trig_count_o(trig_count_o)
    );

    int checks = 0;
    int errors = 0;
    int cur_th, cur_hold;

    int   stim0[MAXC], stim1[MAXC];
    logic stim_arm[MAXC], stim_rst[MAXC];
    logic obs_trig[MAXC], obs_tidx[MAXC], obs_pv[MAXC];
    int   obs_pk[MAXC], obs_pki[MAXC], obs_cnt[MAXC];
    logic exp_trig[MAXC], exp_tidx[MAXC], exp_pv[MAXC];
    int   exp_pk[MAXC], exp_pki[MAXC], exp_cnt[MAXC];

    function automatic int mag(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            stim0[c] = 0; stim1[c] = 0; stim_arm[c] = 1'b1; stim_rst[c] = 1'b0;
        end
    endtask

    // Reset, then present stim[c] in cycle c; obs[c] holds the outputs seen in cycle c.
    task automatic run_pairs(input int n);
        rst = 1'b1; arm = 1'b1; in0 = '0; in1 = '0;
        thresh = 16'(cur_th); holdoff = 16'(cur_hold);
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < n; c++) begin
            obs_trig[c] = trig_o; obs_tidx[c] = trig_idx_o; obs_pv[c] = peak_valid_o;
            obs_pk[c] = int'(peak_o); obs_pki[c] = int'(peak_idx_o); obs_cnt[c] = int'(trig_count_o);
            rst = stim_rst[c]; arm = stim_arm[c];
            in0 = 16'(stim0[c]); in1 = 16'(stim1[c]);
            @(posedge clk);
            #1;
        end
        in0 = '0; in1 = '0;
    endtask

    // Event-level reference: a hit pair p (when eligible) triggers at p+3, its window is
    // pairs p..p+L-1, the peak reports L cycles later, and the next eligible pair is p+L+H+2.
    task automatic model(input int n);
        int e, cnt, best, bidx, t, m;
        for (int c = 0; c < MAXC; c++) begin
            exp_trig[c] = 1'b0; exp_tidx[c] = 1'b0; exp_pv[c] = 1'b0;
            exp_pk[c] = 0; exp_pki[c] = 0; exp_cnt[c] = 0;
        end
        e = 0; cnt = 0;
        for (int p = 0; p < n; p++) begin
            if (p >= e && (mag(stim0[p]) > cur_th || mag(stim1[p]) > cur_th)) begin
                t = p + 3;
                cnt++;
                exp_trig[t] = 1'b1;
                exp_tidx[t] = (mag(stim0[p]) > cur_th) ? 1'b0 : 1'b1;
                exp_cnt[t]  = cnt;
                best = -1; bidx = 0;
                for (int j = 0; j < L; j++) begin
                    for (int s = 0; s < 2; s++) begin
                        m = mag((s == 0) ? stim0[p+j] : stim1[p+j]);
                        if (m > best) begin best = m; bidx = 2*j + s; end
                    end
                end
                if (t + L < MAXC) begin
                    exp_pv[t+L] = 1'b1; exp_pk[t+L] = best; exp_pki[t+L] = bidx;
                end
                e = p + L + cur_hold + 2;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b1; in0 = 16'h7FFF; in1 = 16'h8001; thresh = '0; holdoff = 16'd3;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (trig_o !== 1'b0)       begin errors++; $display("[TB] FAIL reset_trig got %b want 0", trig_o); end
        if (trig_idx_o !== 1'b0)   begin errors++; $display("[TB] FAIL reset_trig_idx got %b want 0", trig_idx_o); end
        if (peak_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_peak_valid got %b want 0", peak_valid_o); end
        if (peak_o !== 16'd0)      begin errors++; $display("[TB] FAIL reset_peak got %0h want 0", peak_o); end
        if (peak_idx_o !== 4'd0)   begin errors++; $display("[TB] FAIL reset_peak_idx got %0d want 0", peak_idx_o); end
        if (trig_count_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", trig_count_o); end
    endtask

    task automatic test_first_cross();
        int pulses;
        clear_stim(); cur_th = 100; cur_hold = 0;
        stim0[10] = -101;
        run_pairs(40);
        pulses = 0;
        for (int c = 0; c < 40; c++) pulses += int'(obs_trig[c]);
        checks += 6;
        if (pulses != 1) begin errors++; $display("[TB] FAIL first_cross_pulses got %0d want 1", pulses); end
        if (obs_trig[13] !== 1'b1 || obs_tidx[13] !== 1'b0)
            begin errors++; $display("[TB] FAIL first_cross_trig13 got trig=%b idx=%b want 1/0", obs_trig[13], obs_tidx[13]); end
        if (obs_cnt[13] != 1) begin errors++; $display("[TB] FAIL first_cross_count got %0d want 1", obs_cnt[13]); end
        if (obs_pv[20] !== 1'b0 || obs_pv[21] !== 1'b1)
            begin errors++; $display("[TB] FAIL first_cross_pv got c20=%b c21=%b want 0/1", obs_pv[20], obs_pv[21]); end
        if (obs_pk[21] != 101) begin errors++; $display("[TB] FAIL first_cross_peak got %0d want 101", obs_pk[21]); end
        if (obs_pki[21] != 0)  begin errors++; $display("[TB] FAIL first_cross_peak_idx got %0d want 0", obs_pki[21]); end
    endtask

    task automatic test_equal_and_idx();
        int pulses;
        clear_stim(); cur_th = 100; cur_hold = 0;
        stim0[5] = 100;  stim1[5] = 101;
        stim0[30] = 100; stim1[30] = -100;
        stim0[40] = -300; stim1[40] = 400;
        run_pairs(60);
        pulses = 0;
        for (int c = 0; c < 60; c++) pulses += int'(obs_trig[c]);
        checks += 5;
        if (pulses != 2) begin errors++; $display("[TB] FAIL equal_pulses got %0d want 2", pulses); end
        if (obs_trig[8] !== 1'b1 || obs_tidx[8] !== 1'b1)
            begin errors++; $display("[TB] FAIL equal_idx1 got trig=%b idx=%b want 1/1", obs_trig[8], obs_tidx[8]); end
        if (obs_pv[16] !== 1'b1 || obs_pk[16] != 101 || obs_pki[16] != 1)
            begin errors++; $display("[TB] FAIL equal_peak got pv=%b pk=%0d idx=%0d want 1/101/1", obs_pv[16], obs_pk[16], obs_pki[16]); end
        if (obs_trig[43] !== 1'b1 || obs_tidx[43] !== 1'b0 || obs_cnt[43] != 2)
            begin errors++; $display("[TB] FAIL both_hit_idx0 got trig=%b idx=%b cnt=%0d want 1/0/2", obs_trig[43], obs_tidx[43], obs_cnt[43]); end
        if (obs_pv[51] !== 1'b1 || obs_pk[51] != 400 || obs_pki[51] != 1)
            begin errors++; $display("[TB] FAIL both_hit_peak got pv=%b pk=%0d idx=%0d want 1/400/1", obs_pv[51], obs_pk[51], obs_pki[51]); end
    endtask

    task automatic test_window_tie();
        clear_stim(); cur_th = 100; cur_hold = 0;
        stim1[5] = 150; stim0[7] = 200; stim1[9] = -200;
        run_pairs(30);
        checks += 2;
        if (obs_trig[8] !== 1'b1 || obs_tidx[8] !== 1'b1)
            begin errors++; $display("[TB] FAIL tie_trig got trig=%b idx=%b want 1/1", obs_trig[8], obs_tidx[8]); end
        if (obs_pv[16] !== 1'b1 || obs_pk[16] != 200 || obs_pki[16] != 4)
            begin errors++; $display("[TB] FAIL tie_peak got pv=%b pk=%0d idx=%0d want 1/200/4", obs_pv[16], obs_pk[16], obs_pki[16]); end
    endtask

    task automatic test_min_value();
        clear_stim(); cur_th = 32767; cur_hold = 0;
        stim0[4] = -32768; stim1[4] = 32767;
        run_pairs(30);
        checks += 2;
        if (obs_trig[7] !== 1'b1 || obs_tidx[7] !== 1'b0)
            begin errors++; $display("[TB] FAIL minval_trig got trig=%b idx=%b want 1/0", obs_trig[7], obs_tidx[7]); end
        if (obs_pv[15] !== 1'b1 || obs_pk[15] != 32768 || obs_pki[15] != 0)
            begin errors++; $display("[TB] FAIL minval_peak got pv=%b pk=%0d idx=%0d want 1/32768/0", obs_pv[15], obs_pk[15], obs_pki[15]); end
    endtask

    task automatic test_holdoff_period();
        int period;
        logic et, ep;
        clear_stim(); cur_th = 100; cur_hold = 5;
        for (int c = 0; c < 100; c++) stim0[c] = 500;
        run_pairs(100);
        period = L + (cur_hold + 1) + 1;
        for (int c = 0; c < 100; c++) begin
            et = (c >= 3) && ((c - 3) % period == 0);
            ep = (c >= 3 + L) && ((c - 3 - L) % period == 0);
            checks++;
            if (obs_trig[c] !== et || obs_pv[c] !== ep)
                begin errors++; $display("[TB] FAIL holdoff_pulses c%0d got trig=%b pv=%b want %b/%b", c, obs_trig[c], obs_pv[c], et, ep); end
            if (et) begin
                checks++;
                if (obs_cnt[c] != (c - 3) / period + 1)
                    begin errors++; $display("[TB] FAIL holdoff_count c%0d got %0d want %0d", c, obs_cnt[c], (c - 3) / period + 1); end
            end
        end
    endtask

    task automatic test_arm_drop();
        int pulses, pvs;
        clear_stim(); cur_th = 100; cur_hold = 0;
        for (int c = 0; c < 45; c++) stim0[c] = 500;
        for (int c = 6; c < 20; c++) stim_arm[c] = 1'b0;
        run_pairs(45);
        pulses = 0; pvs = 0;
        for (int c = 4; c < 23; c++) pulses += int'(obs_trig[c]);
        for (int c = 0; c < 31; c++) pvs += int'(obs_pv[c]);
        checks += 5;
        if (obs_trig[3] !== 1'b1) begin errors++; $display("[TB] FAIL armdrop_first got %b want 1", obs_trig[3]); end
        if (pulses != 0) begin errors++; $display("[TB] FAIL armdrop_idle_trigs got %0d want 0", pulses); end
        if (pvs != 0 || obs_pk[30] != 0)
            begin errors++; $display("[TB] FAIL armdrop_aborted got pv=%0d pk=%0d want 0/0", pvs, obs_pk[30]); end
        if (obs_trig[23] !== 1'b1 || obs_cnt[23] != 2)
            begin errors++; $display("[TB] FAIL armdrop_rearm got trig=%b cnt=%0d want 1/2", obs_trig[23], obs_cnt[23]); end
        if (obs_pv[31] !== 1'b1 || obs_pk[31] != 500)
            begin errors++; $display("[TB] FAIL armdrop_peak got pv=%b pk=%0d want 1/500", obs_pv[31], obs_pk[31]); end
    endtask

    task automatic test_rst_mid_peak();
        int pulses, pvs;
        clear_stim(); cur_th = 100; cur_hold = 0;
        for (int c = 0; c < 30; c++) stim0[c] = 500;
        stim_rst[6] = 1'b1;
        run_pairs(30);
        pulses = 0; pvs = 0;
        for (int c = 4; c < 10; c++) pulses += int'(obs_trig[c]);
        for (int c = 0; c < 18; c++) pvs += int'(obs_pv[c]);
        checks += 5;
        if (obs_trig[3] !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_first got %b want 1", obs_trig[3]); end
        if (obs_cnt[7] != 0 || obs_pk[7] != 0 || obs_pki[7] != 0 || obs_tidx[7] !== 1'b0)
            begin errors++; $display("[TB] FAIL rstmid_cleared got cnt=%0d pk=%0d idx=%0d tidx=%b want 0", obs_cnt[7], obs_pk[7], obs_pki[7], obs_tidx[7]); end
        if (pulses != 0 || pvs != 0)
            begin errors++; $display("[TB] FAIL rstmid_flushed got trigs=%0d pvs=%0d want 0/0", pulses, pvs); end
        if (obs_trig[10] !== 1'b1 || obs_cnt[10] != 1)
            begin errors++; $display("[TB] FAIL rstmid_retrig got trig=%b cnt=%0d want 1/1", obs_trig[10], obs_cnt[10]); end
        if (obs_pv[18] !== 1'b1 || obs_pk[18] != 500)
            begin errors++; $display("[TB] FAIL rstmid_peak got pv=%b pk=%0d want 1/500", obs_pv[18], obs_pk[18]); end
    endtask

    task automatic test_random();
        int n, v;
        n = 160;
        for (int it = 0; it < 4; it++) begin
            clear_stim();
            cur_th = int'($urandom_range(50, 20000));
            cur_hold = int'($urandom_range(0, 6));
            for (int c = 0; c < n - 20; c++) begin
                for (int s = 0; s < 2; s++) begin
                    if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, 65535)) - 32768;
                    else begin
                        v = int'($urandom_range(0, cur_th));
                        if ($urandom_range(0, 1) == 1) v = -v;
                    end
                    if (s == 0) stim0[c] = v; else stim1[c] = v;
                end
            end
            run_pairs(n);
            model(n);
            for (int c = 0; c < n; c++) begin
                checks++;
                if (obs_trig[c] !== exp_trig[c] || obs_pv[c] !== exp_pv[c])
                    begin errors++; $display("[TB] FAIL random_pulses run%0d c%0d got trig=%b pv=%b want %b/%b", it, c, obs_trig[c], obs_pv[c], exp_trig[c], exp_pv[c]); end
                if (exp_trig[c]) begin
                    checks++;
                    if (obs_tidx[c] !== exp_tidx[c] || obs_cnt[c] != exp_cnt[c])
                        begin errors++; $display("[TB] FAIL random_trig run%0d c%0d got idx=%b cnt=%0d want %b/%0d", it, c, obs_tidx[c], obs_cnt[c], exp_tidx[c], exp_cnt[c]); end
                end
                if (exp_pv[c]) begin
                    checks++;
                    if (obs_pk[c] != exp_pk[c] || obs_pki[c] != exp_pki[c])
                        begin errors++; $display("[TB] FAIL random_peak run%0d c%0d got pk=%0d idx=%0d want %0d/%0d", it, c, obs_pk[c], obs_pki[c], exp_pk[c], exp_pki[c]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_cross();
        test_equal_and_idx();
        test_window_tie();
        test_min_value();
        test_holdoff_period();
        test_arm_drop();
        test_rst_mid_peak();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
